// File: rtl/neuron_accumulator.sv
// Frame accumulator for signed neuron partial sums: saturating 16-bit accumulate,
// then requantize (shift, optional ReLU, clamp) into one registered activation per frame.
module neuron_accumulator #(
  parameter  int IN_W    = 16,
  parameter  int ACC_W   = 16,
  parameter  int OUT_W   = 8,
  parameter  int SHIFT   = 4,
  parameter  int RELU_EN = 1,
  parameter  int N_MAX   = 16,
  localparam int CNT_W   = $clog2(N_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {
    ST_ACCUM,
    ST_OUTPUT
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        N_MAX_C = CNT_W'(N_MAX);

  state_t                   r_state;
  state_t                   w_state_next;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_count;
  logic                     r_ovf;
  logic [OUT_W-1:0]         r_out_data;
  logic [CNT_W-1:0]         r_out_count;
  logic                     r_out_ovf;

  logic                     w_accept;
  logic                     w_close;
  logic                     w_out_hs;
  logic signed [ACC_W:0]    w_acc_ext;
  logic signed [ACC_W:0]    w_in_ext;
  logic signed [ACC_W:0]    w_sum;
  logic                     w_sum_ovf;
  logic signed [ACC_W-1:0]  w_acc_upd;
  logic [CNT_W-1:0]         w_count_inc;
  logic signed [ACC_W-1:0]  w_shr;
  logic signed [ACC_W-1:0]  w_relu;
  logic signed [ACC_W-1:0]  w_sat;
  logic [OUT_W-1:0]         w_act;

  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_OUTPUT);
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  assign w_accept    = in_valid & in_ready;
  assign w_out_hs    = out_valid & out_ready;
  assign w_count_inc = r_count + CNT_W'(1);
  // in_last and the N_MAX-th beat collapse into a single close event
  assign w_close     = w_accept & (in_last | (w_count_inc == N_MAX_C));

  // Carry out of the sign bit is detected one bit above the accumulator
  assign w_acc_ext = {r_acc[ACC_W-1], r_acc};
  assign w_in_ext  = (ACC_W+1)'($signed(in_data));
  assign w_sum     = w_acc_ext + w_in_ext;
  assign w_sum_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    w_acc_upd = w_sum[ACC_W-1:0];
    if (w_sum_ovf) begin
      w_acc_upd = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    w_shr  = w_acc_upd >>> SHIFT;
    w_relu = w_shr;
    if ((RELU_EN != 0) && w_shr[ACC_W-1]) begin
      w_relu = '0;
    end
    w_sat = w_relu;
    if (w_relu > OUT_MAX) begin
      w_sat = OUT_MAX;
    end else if (w_relu < OUT_MIN) begin
      w_sat = OUT_MIN;
    end
    w_act = w_sat[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM:  if (w_close)   w_state_next = ST_OUTPUT;
      ST_OUTPUT: if (out_ready) w_state_next = ST_ACCUM;
      default:                  w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_upd;
      r_count <= w_count_inc;
      r_ovf   <= r_ovf | w_sum_ovf;
      if (w_close) begin
        r_out_data  <= w_act;
        r_out_count <= w_count_inc;
        r_out_ovf   <= r_ovf | w_sum_ovf;
      end
    end else if (w_out_hs) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end
  end

endmodule
